// File: rtl/router_fsm_np.sv
// Packet router control FSM: decodes the header address, sequences FIFO writes,
// waits for a busy destination with an optional timeout and discards bad packets.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header written to the destination FIFO
// WAIT_TILL_EMPTY    | destination FIFO still draining, timeout counter running
// LOAD_DATA          | payload bytes streaming into the FIFO
// LOAD_PARITY        | parity byte being written
// FIFO_FULL_STATE    | destination FIFO full, writes stalled
// LOAD_AFTER_FULL    | byte held during the stall is written
// CHECK_PARITY_ERROR | packet complete, internal registers cleared
// DROP_PACKET        | packet discarded until pkt_valid falls
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_packet_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic                 drop_state,
    output logic [ADDR_W-1:0]    dest_port,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        WAIT_TILL_EMPTY    = 4'd2,
        LOAD_DATA          = 4'd3,
        LOAD_PARITY        = 4'd4,
        FIFO_FULL_STATE    = 4'd5,
        LOAD_AFTER_FULL    = 4'd6,
        CHECK_PARITY_ERROR = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    localparam int                CNT_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   PORTS_W  = (ADDR_W + 1)'(NUM_PORTS);

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     wait_cnt;
    logic [2**ADDR_W-1:0] empty_map;
    logic [2**ADDR_W-1:0] srst_map;
    logic                 addr_ok;
    logic                 wait_hit;
    logic                 soft_hit;

    // Widen per-port flags to the full address space so any address indexes safely.
    always_comb begin
        empty_map = '0;
        srst_map  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            empty_map[i] = fifo_empty[i];
            srst_map[i]  = soft_reset[i];
        end
    end

    assign addr_ok  = ({1'b0, data_in} < PORTS_W);
    assign wait_hit = (WAIT_TIMEOUT > 0) && (wait_cnt == CNT_LAST);
    assign soft_hit = srst_map[dest_port] &&
                      (state != DECODE_ADDRESS) && (state != DROP_PACKET);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        state_nx = DROP_PACKET;
                    end else if (empty_map[data_in]) begin
                        state_nx = LOAD_FIRST_DATA;
                    end else begin
                        state_nx = WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_map[dest_port]) begin
                    state_nx = LOAD_FIRST_DATA;
                end else if (wait_hit) begin
                    state_nx = DROP_PACKET;
                end
            end
            LOAD_FIRST_DATA: state_nx = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_nx = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_nx = LOAD_PARITY;
                end
            end
            LOAD_PARITY: state_nx = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_nx = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_nx = DECODE_ADDRESS;
                end else if (low_packet_valid) begin
                    state_nx = LOAD_PARITY;
                end else begin
                    state_nx = LOAD_DATA;
                end
            end
            CHECK_PARITY_ERROR: begin
                state_nx = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    state_nx = DECODE_ADDRESS;
                end
            end
            default: state_nx = DECODE_ADDRESS;
        endcase
        if (soft_hit) begin
            state_nx = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest_port <= '0;
        end else if ((state == DECODE_ADDRESS) && pkt_valid) begin
            dest_port <= data_in;
        end
    end

    // Held at zero outside WAIT_TILL_EMPTY, so every entry starts a fresh count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT_TILL_EMPTY) begin
            wait_cnt <= '0;
        end else if (!empty_map[dest_port] && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

    // Only a timeout can take WAIT_TILL_EMPTY to DROP_PACKET.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == WAIT_TILL_EMPTY) && (state_nx == DROP_PACKET);
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        drop_state    = 1'b0;
        case (state)
            DECODE_ADDRESS:  detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            DROP_PACKET: drop_state = 1'b1;
            default: detect_add = 1'b0;
        endcase
    end

endmodule

// File: doc/router_fsm_np.md
ROUTER_FSM_NP -- requirements
Module: router_fsm_np

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of destination FIFOs (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 2, header address width; NUM_PORTS <= 2**ADDR_W.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 255, max cycles in WAIT_TILL_EMPTY (0 = no timeout).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 pkt_valid  in  1  source packet valid.
REQ-008 data_in  in  ADDR_W  header address bits.
REQ-009 fifo_full  in  1  full flag of the selected FIFO.
REQ-010 fifo_empty  in  NUM_PORTS  per-port FIFO empty flags.
REQ-011 soft_reset  in  NUM_PORTS  per-port soft reset, synchronous.
REQ-012 parity_done  in  1  parity byte written.
REQ-013 low_packet_valid  in  1  pkt_valid fell while FIFO full.
REQ-014 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy  out  1 each  state decodes.
REQ-015 drop_state  out  1  packet being discarded.
REQ-016 dest_port  out  ADDR_W  latched destination address.
REQ-017 timeout_err  out  1  one-cycle WAIT timeout pulse.

Function
REQ-018 States: DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET; registered, 4-bit encoding.
REQ-019 DECODE_ADDRESS, pkt_valid=1: data_in>=NUM_PORTS -> DROP_PACKET; else fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY; pkt_valid=0 -> stay.
REQ-020 dest_port SHALL load data_in on every DECODE_ADDRESS cycle with pkt_valid=1; hold otherwise.
REQ-021 WAIT_TILL_EMPTY: fifo_empty[dest_port]=1 -> LOAD_FIRST_DATA (other ports' flags ignored); else wait counter increments; counter==WAIT_TIMEOUT-1 with WAIT_TIMEOUT>0 -> DROP_PACKET.
REQ-022 Wait counter SHALL clear on every entry to WAIT_TILL_EMPTY; width clog2(WAIT_TIMEOUT+1), no wrap.
REQ-023 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-024 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE (priority); else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-025 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-026 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-027 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_packet_valid=1 -> LOAD_PARITY; else LOAD_DATA.
REQ-028 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-029 DROP_PACKET: pkt_valid=0 -> DECODE_ADDRESS; else stay.
REQ-030 soft_reset[dest_port]=1 in any state except DECODE_ADDRESS/DROP_PACKET SHALL force DECODE_ADDRESS next cycle, overriding REQ-019..029; other ports' soft_reset bits ignored.
REQ-031 Outputs combinational from state: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET.
REQ-032 write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL only; never in DROP_PACKET.
REQ-033 busy=1 in all states except DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
REQ-034 timeout_err SHALL be registered, high exactly in the first DROP_PACKET cycle entered via REQ-021 timeout; low for address-invalid drops.

Reset
REQ-035 reset=1 SHALL asynchronously force DECODE_ADDRESS, dest_port=0, wait counter=0, timeout_err=0; hence detect_add=1, all other outputs 0.
REQ-036 Reset mid-packet SHALL abandon the packet with no further write_enb_reg.

Verification
REQ-037 fifo_empty=3'b111, data_in=2, pkt_valid 1 for 4 cycles -> DECODE,LFD,LD x3,LOAD_PARITY,CHECK,DECODE; dest_port=2.
REQ-038 fifo_empty=3'b011, data_in=2, WAIT_TIMEOUT=4, empty never rises -> 4 WAIT cycles, DROP_PACKET with timeout_err=1 one cycle; DECODE after pkt_valid falls.
REQ-039 data_in=3 with NUM_PORTS=3 -> DROP_PACKET, timeout_err=0, write_enb_reg=0 throughout.
REQ-040 fifo_empty=3'b011, data_in=2, fifo_empty[0] toggles -> stays WAIT; fifo_empty[2] rises -> LOAD_FIRST_DATA next cycle.
REQ-041 LOAD_DATA, fifo_full=1 for 3 cycles then 0, low_packet_valid=1 -> FULL x3, LAF, LOAD_PARITY.
REQ-042 Busy on dest_port=1: soft_reset=3'b001 -> no effect; soft_reset=3'b010 -> DECODE next cycle; async reset mid-LOAD_DATA -> detect_add=1 immediately.
